// File: rtl/timer_interrupt_controller.sv
// -----------------------------------------------------------------------------
// timer_interrupt_controller
//
// Programmable down-counting timer with a prescaler, optional auto-reload and
// a level interrupt towards the CPU. It is driven through a four-register bus:
//   address 0 CONTROL : bit0 enable, bit1 auto_reload, bit2 irq_enable (R/W)
//   address 1 PERIOD  : reload value (R/W)
//   address 2 COUNT   : current count (read-only, writes ignored)
//   address 3 STATUS  : bit0 pending, bit1 overrun (write 1 to clear)
//
// Ports
//   clock                 single clock, all state changes on its rising edge
//   reset                 asynchronous, active-high reset
//   address               register select
//   write / read          bus strobes, sampled on the clock edge
//   data_in               write data
//   data_out              registered read data, holds while read is low
//   interrupt_request     pending AND irq_enable
//   interrupt_acknowledge one-cycle pulse from the CPU, clears pending
//
// Timing of a start: the CONTROL write edge arms the timer (COUNT <= PERIOD,
// prescaler <= 0, enable <= 1) while the FSM is still IDLE; the FSM enters
// RUNNING on the following edge and the prescaler counts from there. With
// PRESCALE=P and PERIOD=N the first expiry therefore lands 1 + P*N edges after
// the write edge, and every P*N edges after that in auto-reload mode.
//
// DATA_WIDTH must be at least 3 so CONTROL fits on the data bus.
// -----------------------------------------------------------------------------
module timer_interrupt_controller #(
    parameter int DATA_WIDTH = 16,
    parameter int PRESCALE   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  write,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  interrupt_request,
    input  logic                  interrupt_acknowledge
);

    // A one-bit prescaler is kept even for PRESCALE=1; it simply stays at 0.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]       PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]       PS_ONE    = PS_W'(1);
    localparam logic [DATA_WIDTH-1:0] COUNT_ONE = DATA_WIDTH'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t                  state_reg;
    logic                    enable_reg;
    logic                    auto_reload_reg;
    logic                    irq_enable_reg;
    logic [DATA_WIDTH-1:0]   period_reg;
    logic [DATA_WIDTH-1:0]   count_reg;
    logic [PS_W-1:0]         prescale_reg;
    logic                    pending_reg;
    logic                    overrun_reg;
    logic [DATA_WIDTH-1:0]   data_out_reg;

    logic                    pending_next;
    logic                    overrun_next;

    // -------------------------------------------------------------------------
    // Bus decode
    // -------------------------------------------------------------------------
    logic control_wr;
    logic period_wr;
    logic status_wr;

    assign control_wr = write && (address == 2'd0);
    assign period_wr  = write && (address == 2'd1);
    assign status_wr  = write && (address == 2'd3);

    // -------------------------------------------------------------------------
    // Zero-extended CONTROL / STATUS read words
    // -------------------------------------------------------------------------
    logic [2:0]            control_bits;
    logic [1:0]            status_bits;
    logic [DATA_WIDTH-1:0] control_word;
    logic [DATA_WIDTH-1:0] status_word;

    assign control_bits = {irq_enable_reg, auto_reload_reg, enable_reg};
    assign status_bits  = {overrun_reg, pending_reg};

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_rd_bit
            if (gi < 3) begin : g_ctrl_used
                assign control_word[gi] = control_bits[gi];
            end else begin : g_ctrl_zero
                assign control_word[gi] = 1'b0;
            end
            if (gi < 2) begin : g_stat_used
                assign status_word[gi] = status_bits[gi];
            end else begin : g_stat_zero
                assign status_word[gi] = 1'b0;
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Tick / expiry qualification
    // -------------------------------------------------------------------------
    logic stop_req;
    logic tick;
    logic expiry;
    logic pending_clr;
    logic overrun_clr;

    // A stop request in RUNNING freezes COUNT, so it also suppresses any tick
    // that would have happened on the same edge.
    assign stop_req    = (state_reg == RUNNING) && control_wr && !data_in[0];
    assign tick        = (state_reg == RUNNING) && !stop_req && (prescale_reg == PS_LAST);
    // COUNT <= 1 covers PERIOD=0, which therefore expires every tick like 1.
    assign expiry      = tick && (count_reg <= COUNT_ONE);
    assign pending_clr = interrupt_acknowledge || (status_wr && data_in[0]);
    assign overrun_clr = status_wr && data_in[1];

    // Setting wins over clearing for pending, and an overrun is only recorded
    // when the previous interrupt is still outstanding after this edge's clears.
    always_comb begin
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        if (expiry && pending_reg && !pending_clr) begin
            overrun_next = 1'b1;
        end else if (overrun_clr) begin
            overrun_next = 1'b0;
        end
        if (expiry) begin
            pending_next = 1'b1;
        end else if (pending_clr) begin
            pending_next = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Timer FSM together with CONTROL, COUNT and prescaler
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            enable_reg      <= 1'b0;
            auto_reload_reg <= 1'b0;
            irq_enable_reg  <= 1'b0;
            count_reg       <= '0;
            prescale_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (control_wr) begin
                        enable_reg      <= data_in[0];
                        auto_reload_reg <= data_in[1];
                        irq_enable_reg  <= data_in[2];
                        if (data_in[0]) begin
                            count_reg    <= period_reg;
                            prescale_reg <= '0;
                        end
                    end else if (enable_reg) begin
                        // Armed on the previous edge: start counting now.
                        state_reg <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (stop_req) begin
                        enable_reg      <= 1'b0;
                        auto_reload_reg <= data_in[1];
                        irq_enable_reg  <= data_in[2];
                        prescale_reg    <= '0;
                        state_reg       <= IDLE;
                    end else begin
                        // Re-enabling while running only updates the mode bits.
                        if (control_wr) begin
                            auto_reload_reg <= data_in[1];
                            irq_enable_reg  <= data_in[2];
                        end
                        if (prescale_reg == PS_LAST) begin
                            prescale_reg <= '0;
                        end else begin
                            prescale_reg <= prescale_reg + PS_ONE;
                        end
                        if (tick) begin
                            if (!expiry) begin
                                count_reg <= count_reg - COUNT_ONE;
                            end else if (auto_reload_reg) begin
                                count_reg <= period_reg;
                            end else begin
                                count_reg    <= '0;
                                enable_reg   <= 1'b0;
                                prescale_reg <= '0;
                                state_reg    <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // PERIOD, STATUS and read data
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_reg   <= '0;
            pending_reg  <= 1'b0;
            overrun_reg  <= 1'b0;
            data_out_reg <= '0;
        end else begin
            if (period_wr) begin
                period_reg <= data_in;
            end
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            // Reads sample the registers before this edge's updates, so a
            // same-cycle write to the addressed register returns the old value.
            if (read) begin
                case (address)
                    2'd0:    data_out_reg <= control_word;
                    2'd1:    data_out_reg <= period_reg;
                    2'd2:    data_out_reg <= count_reg;
                    default: data_out_reg <= status_word;
                endcase
            end
        end
    end

    assign data_out          = data_out_reg;
    assign interrupt_request = pending_reg && irq_enable_reg;

endmodule

// File: tb/tb_timer_interrupt_controller.sv
// -----------------------------------------------------------------------------
// Bench for timer_interrupt_controller. Two instances (PRESCALE=1 and
// PRESCALE=4) share one stimulus stream; each has its own behavioural model.
// -----------------------------------------------------------------------------
module tb_timer_interrupt_controller;

    localparam int DW = 16;

    logic          clock   = 1'b0;
    logic          reset   = 1'b1;
    logic [1:0]    address = 2'd0;
    logic          write   = 1'b0;
    logic          read    = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          ack     = 1'b0;

    logic [DW-1:0] dout1;
    logic [DW-1:0] dout4;
    logic          irq1;
    logic          irq4;

    int n_vec = 0;
    int n_err = 0;

    timer_interrupt_controller #(.DATA_WIDTH(DW), .PRESCALE(1)) dut_ps1 (
        .clock                 (clock),
        .reset                 (reset),
        .address               (address),
        .write                 (write),
        .read                  (read),
        .data_in               (data_in),
        .data_out              (dout1),
        .interrupt_request     (irq1),
        .interrupt_acknowledge (ack)
    );

    timer_interrupt_controller #(.DATA_WIDTH(DW), .PRESCALE(4)) dut_ps4 (
        .clock                 (clock),
        .reset                 (reset),
        .address               (address),
        .write                 (write),
        .read                  (read),
        .data_in               (data_in),
        .data_out              (dout4),
        .interrupt_request     (irq4),
        .interrupt_acknowledge (ack)
    );

    always #5 clock = ~clock;

    // ------------------------------------------------------------------
    // Reference model: index 0 -> PRESCALE=1, index 1 -> PRESCALE=4
    // ------------------------------------------------------------------
    int m_period[2];
    int m_count[2];
    int m_phase[2];   // cycles elapsed inside the current tick period
    int m_run[2];     // counting (armed timers start on the following edge)
    int m_en[2];
    int m_ar[2];
    int m_ie[2];
    int m_pend[2];
    int m_ovr[2];
    int m_dout[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_period[m] = 0; m_count[m] = 0; m_phase[m] = 0; m_run[m] = 0;
            m_en[m] = 0; m_ar[m] = 0; m_ie[m] = 0;
            m_pend[m] = 0; m_ovr[m] = 0; m_dout[m] = 0;
        end
    endtask

    // One clock edge of behaviour, evaluated from the bus inputs and the
    // model state before the edge.
    task automatic model_step(input int m);
        int ps, d, old_period, old_count, old_ar;
        bit cw, pw, sw, stop, tk, expire, clr;
        ps         = (m == 0) ? 1 : 4;
        d          = int'(data_in);
        cw         = write && (address == 2'd0);
        pw         = write && (address == 2'd1);
        sw         = write && (address == 2'd3);
        old_period = m_period[m];
        old_count  = m_count[m];
        old_ar     = m_ar[m];

        if (read) begin
            case (address)
                2'd0:    m_dout[m] = m_en[m] + 2 * m_ar[m] + 4 * m_ie[m];
                2'd1:    m_dout[m] = m_period[m];
                2'd2:    m_dout[m] = m_count[m];
                default: m_dout[m] = m_pend[m] + 2 * m_ovr[m];
            endcase
        end

        stop   = (m_run[m] != 0) && cw && !d[0];
        tk     = (m_run[m] != 0) && !stop && (m_phase[m] == ps - 1);
        expire = tk && (old_count <= 1);
        clr    = ack || (sw && d[0]);

        if (expire && m_pend[m] == 1 && !clr) m_ovr[m] = 1;
        else if (sw && d[1])                  m_ovr[m] = 0;
        if (expire)   m_pend[m] = 1;
        else if (clr) m_pend[m] = 0;

        if (pw) m_period[m] = d;

        if (m_run[m] == 0) begin
            if (cw) begin
                m_en[m] = int'(d[0]); m_ar[m] = int'(d[1]); m_ie[m] = int'(d[2]);
                if (d[0]) begin
                    m_count[m] = old_period;
                    m_phase[m] = 0;
                end
            end else if (m_en[m] != 0) begin
                m_run[m] = 1;
            end
        end else if (stop) begin
            m_en[m] = 0; m_ar[m] = int'(d[1]); m_ie[m] = int'(d[2]);
            m_phase[m] = 0; m_run[m] = 0;
        end else begin
            if (cw) begin
                m_ar[m] = int'(d[1]); m_ie[m] = int'(d[2]);
            end
            m_phase[m] = (m_phase[m] + 1) % ps;
            if (tk) begin
                if (old_count > 1)    m_count[m] = old_count - 1;
                else if (old_ar != 0) m_count[m] = old_period;
                else begin
                    m_count[m] = 0; m_en[m] = 0; m_run[m] = 0; m_phase[m] = 0;
                end
            end
        end
    endtask

    // Advance one clock; inputs are stable across the posedge, outputs are
    // compared against the model on the following negedge.
    task automatic cycle();
        @(posedge clock);
        if (!reset) begin
            model_step(0);
            model_step(1);
        end
        @(negedge clock);
        check_eq("dout_ps1", 32'(dout1), 32'(m_dout[0]));
        check_eq("irq_ps1",  32'(irq1),  32'((m_pend[0] != 0) && (m_ie[0] != 0)));
        check_eq("dout_ps4", 32'(dout4), 32'(m_dout[1]));
        check_eq("irq_ps4",  32'(irq4),  32'((m_pend[1] != 0) && (m_ie[1] != 0)));
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
        address = a; data_in = d; write = 1'b1;
        cycle();
        write = 1'b0;
        $display("wr addr=%0d data=%0h", a, d);
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a; read = 1'b1;
        cycle();
        read = 1'b0;
        $display("rd addr=%0d ps1=%0h ps4=%0h", a, dout1, dout4);
    endtask

    // Called right after cycle() (at a negedge): asserts reset immediately.
    task automatic apply_reset();
        write = 1'b0; read = 1'b0; ack = 1'b0;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_irq_ps1",  32'(irq1),  32'(0));
        check_eq("rst_dout_ps1", 32'(dout1), 32'(0));
        check_eq("rst_irq_ps4",  32'(irq4),  32'(0));
        check_eq("rst_dout_ps4", 32'(dout4), 32'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        $display("reset pulse");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int rises[$];
        int prev, highs, nz, ack_pend;
        int exp33[3] = '{4, 7, 10};
        int cnt33[8] = '{3, 3, 2, 1, 3, 2, 1, 3};

        @(negedge clock);
        apply_reset();

        // ---- reset state of every register ----
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a));
            check_eq("rst_reg_ps1", 32'(dout1), 32'(0));
        end

        // ---- PRESCALE=1, PERIOD=3, CONTROL=0b111: expiries at 4, 7, 10 ----
        apply_reset();
        bus_write(2'd1, 16'd3);
        bus_write(2'd0, 16'd7);
        address = 2'd2; read = 1'b1;
        rises.delete(); prev = 0; ack_pend = 0;
        for (int c = 1; c <= 12; c++) begin
            ack = ack_pend[0]; ack_pend = 0;
            cycle();
            if (c <= 8) check_eq("r033_count", 32'(dout1), 32'(cnt33[c-1]));
            if (irq1 && prev == 0) begin
                rises.push_back(c);
                ack_pend = 1;
            end
            prev = int'(irq1);
            $display("run c=%0d count_rd=%0d irq=%0b", c, dout1, irq1);
        end
        ack = 1'b0; read = 1'b0;
        check_eq("r033_nrise", 32'(rises.size()), 32'(3));
        for (int i = 0; i < 3; i++)
            if (i < rises.size()) check_eq("r033_rise", 32'(rises[i]), 32'(exp33[i]));
        bus_write(2'd0, 16'd0);

        // ---- PRESCALE=4, PERIOD=2, one-shot: single expiry 9 edges after write ----
        apply_reset();
        bus_write(2'd1, 16'd2);
        bus_write(2'd0, 16'd5);
        rises.delete(); prev = 0;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            if (irq4 && prev == 0) rises.push_back(c);
            prev = int'(irq4);
        end
        check_eq("r034_nrise", 32'(rises.size()), 32'(1));
        if (rises.size() > 0) check_eq("r034_rise", 32'(rises[0]), 32'(9));
        bus_read(2'd0);
        check_eq("r034_ctrl", 32'(dout4), 32'(4));
        bus_read(2'd2);
        check_eq("r034_count", 32'(dout4), 32'(0));
        ack = 1'b1; cycle(); ack = 1'b0;
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (irq4) highs++;
        end
        check_eq("r034_idle_irq", 32'(highs), 32'(0));

        // ---- overrun after two unacknowledged expiries, then W1C pending ----
        apply_reset();
        bus_write(2'd1, 16'd2);
        bus_write(2'd0, 16'd7);
        for (int c = 0; c < 8; c++) cycle();
        bus_write(2'd0, 16'd4);
        bus_read(2'd3);
        check_eq("r035_status", 32'(dout1), 32'(3));
        check_eq("r035_irq_hi", 32'(irq1), 32'(1));
        bus_write(2'd3, 16'd1);
        bus_read(2'd3);
        check_eq("r035_status_w1c", 32'(dout1), 32'(2));
        check_eq("r035_irq_lo", 32'(irq1), 32'(0));

        // ---- clear coinciding with the second expiry: ack (v=0) / W1C (v=1) ----
        for (int v = 0; v < 2; v++) begin
            apply_reset();
            bus_write(2'd1, 16'd3);
            bus_write(2'd0, 16'd7);
            for (int c = 1; c <= 6; c++) cycle();
            if (v == 0) ack = 1'b1;
            else begin
                address = 2'd3; data_in = 16'd1; write = 1'b1;
            end
            cycle();
            ack = 1'b0; write = 1'b0;
            check_eq("r036_irq", 32'(irq1), 32'(1));
            bus_write(2'd0, 16'd4);
            bus_read(2'd3);
            check_eq("r036_status", 32'(dout1), 32'(1));
        end

        // ---- reset mid-count (COUNT=5): everything zero, no later expiry ----
        apply_reset();
        bus_write(2'd1, 16'd8);
        bus_write(2'd0, 16'd7);
        for (int c = 1; c <= 4; c++) cycle();
        apply_reset();
        highs = 0; nz = 0;
        read = 1'b1;
        for (int c = 0; c < 24; c++) begin
            address = 2'(c % 4);
            cycle();
            if (irq1 || irq4) highs++;
            if (dout1 != 0 || dout4 != 0) nz++;
        end
        read = 1'b0;
        check_eq("r037_irq_highs", 32'(highs), 32'(0));
        check_eq("r037_nonzero", 32'(nz), 32'(0));

        // ---- randomized traffic against the model ----
        apply_reset();
        for (int n = 0; n < 700; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
            end
            write   = ($urandom_range(0, 3) == 0);
            read    = ($urandom_range(0, 1) == 1);
            address = 2'($urandom_range(0, 3));
            data_in = 16'($urandom);
            if (address == 2'd1) data_in = 16'($urandom_range(0, 5));
            if (address == 2'd0) data_in[0] = ($urandom_range(0, 3) != 0);
            ack = ($urandom_range(0, 7) == 0);
            cycle();
            if (write || read)
                $display("rnd n=%0d wr=%0b rd=%0b addr=%0d data=%0h ack=%0b ps1=%0h ps4=%0h",
                         n, write, read, address, data_in, ack, dout1, dout4);
        end
        write = 1'b0; read = 1'b0; ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/timer_interrupt_controller.md
TIMER_INTERRUPT_CONTROLLER -- requirements
Module: timer_interrupt_controller

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, setting the width of the PERIOD and COUNT registers and of the data bus.
REQ-002 The block SHALL have parameter PRESCALE, default 1, setting clock cycles per count tick; legal values >= 1.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port address, input, 2 bits: register select (0 CONTROL, 1 PERIOD, 2 COUNT, 3 STATUS).
REQ-006 The block SHALL have port write, input, 1 bit: register write strobe, sampled at the clock edge.
REQ-007 The block SHALL have port read, input, 1 bit: register read strobe, sampled at the clock edge.
REQ-008 The block SHALL have port data_in, input, DATA_WIDTH bits: write data.
REQ-009 The block SHALL have port data_out, output, DATA_WIDTH bits: registered read data.
REQ-010 The block SHALL have port interrupt_request, output, 1 bit: level interrupt to the CPU.
REQ-011 The block SHALL have port interrupt_acknowledge, input, 1 bit: CPU acknowledge, one-cycle pulse.

Function
REQ-012 CONTROL SHALL be read/write with bit0 enable, bit1 auto_reload and bit2 irq_enable; other bits SHALL read 0.
REQ-013 PERIOD SHALL be read/write; COUNT SHALL be read-only, with writes ignored.
REQ-014 STATUS SHALL use bit0 pending and bit1 overrun; writing 1 to a bit SHALL clear it (W1C), and writing 0 SHALL have no effect.
REQ-015 On read=1, data_out SHALL present the addressed register on the following cycle and hold that value while read=0.
REQ-016 When read and write target the same register in the same cycle, data_out SHALL return the pre-write value.
REQ-017 The FSM SHALL have two states, IDLE and RUNNING.
REQ-018 IDLE -> RUNNING: a CONTROL write with enable=1 SHALL load COUNT<=PERIOD and prescaler<=0, with RUNNING from the next cycle.
REQ-019 RUNNING -> IDLE: a CONTROL write with enable=0 SHALL stop the timer; COUNT holds its value, the prescaler clears, and the next enable reloads COUNT.
REQ-020 In RUNNING, the prescaler SHALL count 0..PRESCALE-1 and a tick SHALL occur on the cycle it equals PRESCALE-1, after which it wraps to 0.
REQ-021 On a tick with COUNT > 1, COUNT SHALL decrement by 1.
REQ-022 On a tick with COUNT <= 1 (expiry), pending SHALL be set, and overrun SHALL be set if pending was already 1 and was not cleared that cycle.
REQ-023 Expiry rate: PERIOD=N (N>=1) SHALL expire every N ticks, and PERIOD=0 SHALL behave as 1.
REQ-024 On expiry with auto_reload=1, COUNT SHALL load PERIOD and the FSM SHALL remain RUNNING.
REQ-025 On expiry with auto_reload=0, COUNT SHALL become 0, enable SHALL clear and the FSM SHALL go to IDLE.
REQ-026 A PERIOD write during RUNNING SHALL NOT alter COUNT and SHALL take effect at the next reload.
REQ-027 interrupt_request SHALL equal pending AND irq_enable, driven combinationally from registers.
REQ-028 interrupt_acknowledge=1 SHALL clear pending and SHALL NOT affect overrun.
REQ-029 When expiry coincides with an acknowledge or a STATUS W1C of pending, set SHALL win: pending stays 1 and overrun is not set.
REQ-030 A CONTROL write with enable=1 while already RUNNING SHALL update auto_reload and irq_enable only, without reloading COUNT.

Reset
REQ-031 Reset SHALL asynchronously force FSM=IDLE and CONTROL, PERIOD, COUNT, prescaler, pending, overrun and data_out to 0, with interrupt_request low immediately.
REQ-032 Reset asserted mid-count SHALL abort the count, with no expiry reported after reset release.

Verification
REQ-033 PRESCALE=1: PERIOD=3, CONTROL=0b111 -> pending and interrupt_request rise at 4, 7, 10 cycles after the write edge; COUNT reads 3,2,1,3,...
REQ-034 PRESCALE=4: PERIOD=2, CONTROL=0b101 (one-shot) -> one expiry 8 cycles after RUNNING entry; then CONTROL reads 0b100, COUNT=0, FSM IDLE.
REQ-035 Auto-reload expiry with no acknowledge -> second expiry sets STATUS=0b11; STATUS write 0b01 -> STATUS=0b10 and interrupt_request falls.
REQ-036 interrupt_acknowledge pulsed on the same cycle as an expiry -> pending remains 1 and overrun remains 0.
REQ-037 Reset pulsed while RUNNING with COUNT=5 -> all registers read 0, interrupt_request 0, and no expiry for 20 cycles after release.
